vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Single-cycle-grant arbiter that shares one single-port, synchronous-read 32-bit RAM between the multicycle RISC-V core and the VGA scanout fetcher. It replaces the dual-ported video path: the scanout requester gets priority so pixels are never late, and a streak limiter guarantees the CPU forward progress. It sits between `riscvmulti`/`vga` and the RAM macro, below the memory-mapped I/O decode. Only RAM-space CPU accesses (`addr[8]==0`) reach it.

## Interface
- `VBASE`, 32'h200: byte offset added to every video address before it reaches RAM.
- `MAX_VSTREAK`, 4: maximum consecutive video grants while the CPU is waiting (1..15).
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `c_req`  in  1  CPU access request; held until `c_gnt`.
- `c_we`  in  1  CPU write enable, qualified by `c_req`.
- `c_addr`  in  32  CPU byte address; bits [1:0] are ignored.
- `c_wdata`  in  32  CPU write data.
- `c_gnt`  out  1  CPU request accepted this cycle.
- `c_rvalid`  out  1  CPU read data valid.
- `c_rdata`  out  32  CPU read data.
- `v_req`  in  1  video word-fetch request; held until `v_gnt`.
- `v_addr`  in  32  video byte address, relative to `VBASE`.
- `v_gnt`  out  1  video request accepted this cycle.
- `v_rvalid`  out  1  video read data valid.
- `v_rdata`  out  32  video read data.
- `m_en`  out  1  RAM access strobe.
- `m_we`  out  1  RAM write enable.
- `m_addr`  out  32  RAM byte address, word-aligned (bits [1:0] forced to 0).
- `m_wdata`  out  32  RAM write data.
- `m_rdata`  in  32  RAM read data, valid one cycle after a read strobe.

## Operation
- FSM `st`: `VPRI` (reset state) and `CTURN`.
  - In `VPRI`, video wins whenever `v_req` is asserted.
  - In `CTURN`, the CPU wins whenever `c_req` is asserted.
  - If only one side requests, that side wins in either state.
- Grants are combinational from the registered state and the current requests. At most one of `c_gnt`/`v_gnt` is asserted per cycle. Both are forced to 0 while `reset_n` is low.
- The RAM port mirrors the winner in the same cycle:
  - `m_en` = `c_gnt | v_gnt`.
  - `m_we` = `c_gnt & c_we`. Video is read-only.
  - `m_addr` = (`c_gnt` ? `c_addr` : `v_addr + VBASE`) & ~3. The addition is 32-bit modulo: it wraps and sets no flag.
  - `m_wdata` = `c_wdata`.
- Streak counter `vstreak` (4 bits):
  - +1 on each `v_gnt` while `c_req` is high.
  - Cleared on `c_gnt` or on any cycle with `c_req` low.
- FSM transitions:
  - `VPRI`→`CTURN` when `v_gnt & c_req & (vstreak+1 == MAX_VSTREAK)`.
  - `CTURN`→`VPRI` on `c_gnt`, or when `c_req` is low.
- Read-return tracking uses a registered owner tag `rd_own` ∈ {NONE, CPU, VID}. It is set each cycle from the grant: a read grant sets its owner, a write or no grant sets NONE.
  - Next cycle: `c_rvalid`=(`rd_own`==CPU) and `v_rvalid`=(`rd_own`==VID).
  - `c_rdata`/`v_rdata` are loaded from `m_rdata` only for their own owner and otherwise hold their last value.
- CPU writes produce no `c_rvalid`.

## Timing
- Reset values: `st`=`VPRI`, `vstreak`=0, `rd_own`=NONE; `c_rvalid`=`v_rvalid`=0; `c_rdata`=`v_rdata`=0. Grants and `m_en`/`m_we` are 0 during reset.
- Grant latency is 0 cycles: a request asserted in cycle N with no contention is granted in cycle N.
- Read latency: the grant in cycle N is followed by `*_rvalid` and data in cycle N+1. Back-to-back reads sustain one word per cycle.
- Worst-case CPU wait under continuous video requests is `MAX_VSTREAK` cycles.
- Reset asserted mid-read: the pending `rvalid` is dropped and no data is returned after release.
- A requester deasserting `*_req` without a grant is legal and leaves no state behind except the `vstreak` clear described above.

## Structure
- Package `vram_arb_pkg` holds:
  - enum `arb_state_t` {`VPRI`, `CTURN`};
  - enum `owner_t` {`OWN_NONE`, `OWN_CPU`, `OWN_VID`};
  - the default constants `VBASE_DEF`=32'h200 and `MAX_VSTREAK_DEF`=4.
- Single module, no sub-modules. The streak counter and the FSM live in one `always_ff` block with asynchronous reset.

## Test plan
- CPU-only read, `c_addr`=32'h10: `c_gnt` in the same cycle, `m_addr`=32'h10, `m_we`=0. The next cycle has `c_rvalid`=1 and `c_rdata` equal to the RAM word; `v_rvalid` stays 0.
- Video-only read, `v_addr`=32'h7: `m_addr`=32'h204. `v_rvalid` follows after 1 cycle; no `c_*` activity.
- Contention with `c_req` and `v_req` both held high and `MAX_VSTREAK`=4: grant sequence V,V,V,V,C,V,V,V,V,C…; `c_gnt` every 5th cycle.
- CPU write to 32'h40 with data 32'hDEADBEEF: `m_we`=1, `m_wdata`=32'hDEADBEEF in the grant cycle; no `c_rvalid` afterwards.
- Address wrap, `v_addr`=32'hFFFFFF00: `m_addr`=32'h00000100; no error or flag.
- Read granted, then `reset_n` pulsed low in the next cycle before the clock edge: `c_rvalid`=`v_rvalid`=0, `*_rdata`=0, and `st`=`VPRI` after release.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared types and defaults for the video/CPU RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vram_arb_pkg;

    typedef enum logic {
        VPRI  = 1'b0,
        CTURN = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_t;

    localparam logic [31:0] VBASE_DEF       = 32'h200;
    localparam int          MAX_VSTREAK_DEF = 4;

endpackage

// File: rtl/vram_arbiter.sv
// Shares one synchronous-read RAM port between CPU and video scanout; video has priority, CPU gets a turn after a streak.
// Latency: grant in the request cycle, read data and rvalid one cycle after the grant.
// Backpressure: a requester holds *_req until its *_gnt; the CPU waits at most MAX_VSTREAK cycles.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter logic [31:0] VBASE       = VBASE_DEF,
    parameter int          MAX_VSTREAK = MAX_VSTREAK_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    input  logic        v_req,
    input  logic [31:0] v_addr,
    output logic        v_gnt,
    output logic        v_rvalid,
    output logic [31:0] v_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata
);

    // vstreak+1 == MAX_VSTREAK is the same as vstreak == MAX_VSTREAK-1 for MAX_VSTREAK in 1..15
    localparam logic [3:0] STREAK_LAST = 4'(MAX_VSTREAK - 1);

    arb_state_t  st;
    logic [3:0]  vstreak;
    owner_t      rd_own;
    logic [31:0] c_rdata_q;
    logic [31:0] v_rdata_q;
    logic [31:0] v_addr_ram;

    // Grant selection: the favoured side wins a collision, a lone requester always wins; nothing during reset
    always_comb begin
        c_gnt = 1'b0;
        v_gnt = 1'b0;
        if (reset_n) begin
            if (st == VPRI) begin
                v_gnt = v_req;
                c_gnt = c_req & ~v_req;
            end else begin
                c_gnt = c_req;
                v_gnt = v_req & ~c_req;
            end
        end
    end

    // Video addresses are relative to the frame buffer base; the add wraps silently
    assign v_addr_ram = v_addr + VBASE;

    assign m_en    = c_gnt | v_gnt;
    assign m_we    = c_gnt & c_we;
    assign m_addr  = (c_gnt ? c_addr : v_addr_ram) & ~32'h3;
    assign m_wdata = c_wdata;

    // Streak counter and priority FSM: hand the CPU a turn once video has won MAX_VSTREAK times in a row
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st      <= VPRI;
            vstreak <= 4'd0;
        end else begin
            if (c_gnt || !c_req) begin
                vstreak <= 4'd0;
            end else if (v_gnt) begin
                vstreak <= vstreak + 4'd1;
            end

            case (st)
                VPRI: begin
                    if (v_gnt && c_req && (vstreak == STREAK_LAST)) begin
                        st <= CTURN;
                    end
                end
                CTURN: begin
                    if (c_gnt || !c_req) begin
                        st <= VPRI;
                    end
                end
                default: st <= VPRI;
            endcase
        end
    end

    // Remember who owns the read data returning next cycle; writes return nothing
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_own <= OWN_NONE;
        end else if (c_gnt && !c_we) begin
            rd_own <= OWN_CPU;
        end else if (v_gnt) begin
            rd_own <= OWN_VID;
        end else begin
            rd_own <= OWN_NONE;
        end
    end

    assign c_rvalid = (rd_own == OWN_CPU);
    assign v_rvalid = (rd_own == OWN_VID);

    // Read data passes straight through in the return cycle and is held afterwards
    assign c_rdata = c_rvalid ? m_rdata : c_rdata_q;
    assign v_rdata = v_rvalid ? m_rdata : v_rdata_q;

    // Holding registers for the last word returned to each side
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c_rdata_q <= 32'd0;
            v_rdata_q <= 32'd0;
        end else begin
            c_rdata_q <= c_rdata;
            v_rdata_q <= v_rdata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural RAM and a read-return scoreboard.
// Latency: checks grants in the request cycle and returns one cycle later.
// Backpressure: requests are held by the bench until the expected grant.
module tb_vram_arbiter;
    import vram_arb_pkg::*;

    localparam logic [31:0] VB = 32'h200;

    typedef struct packed {
        logic        c;
        logic        v;
        logic [31:0] d;
    } ret_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        c_req, c_we, c_gnt, c_rvalid;
    logic [31:0] c_addr, c_wdata, c_rdata;
    logic        v_req, v_gnt, v_rvalid;
    logic [31:0] v_addr, v_rdata;
    logic        m_en, m_we;
    logic [31:0] m_addr, m_wdata, m_rdata;

    logic [31:0] mem [0:1023];
    bit          written [0:1023];
    ret_t        q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.VBASE(VB), .MAX_VSTREAK(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .v_req(v_req), .v_addr(v_addr), .v_gnt(v_gnt),
        .v_rvalid(v_rvalid), .v_rdata(v_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    function automatic logic [31:0] pattern(input logic [9:0] idx);
        return {16'hA5C3 ^ {6'b0, idx}, 6'b0, idx};
    endfunction

    function automatic logic [31:0] exp_word(input logic [9:0] idx);
        return written[idx] ? mem[idx] : pattern(idx);
    endfunction

    // Single-port synchronous-read RAM model
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) begin
                mem[m_addr[11:2]]     <= m_wdata;
                written[m_addr[11:2]] <= 1'b1;
            end else begin
                m_rdata <= exp_word(m_addr[11:2]);
            end
        end
    end

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One cycle: check returns owed from last cycle, check this cycle's grant, queue next return
    task automatic step(input logic ec, input logic ev, input logic ewe,
                        input logic [31:0] ea, input string tag);
        ret_t        e;
        ret_t        n;
        logic [31:0] va;
        @(negedge clk);
        e = '0;
        if (q.size() > 0) e = q.pop_front();
        chk(32'(c_rvalid), 32'(e.c), {tag, ":c_rvalid"});
        chk(32'(v_rvalid), 32'(e.v), {tag, ":v_rvalid"});
        if (e.c) chk(c_rdata, e.d, {tag, ":c_rdata"});
        if (e.v) chk(v_rdata, e.d, {tag, ":v_rdata"});
        chk(32'(c_gnt), 32'(ec), {tag, ":c_gnt"});
        chk(32'(v_gnt), 32'(ev), {tag, ":v_gnt"});
        chk(32'(m_en), 32'(ec | ev), {tag, ":m_en"});
        chk(32'(m_we), 32'(ewe), {tag, ":m_we"});
        if (ec | ev) chk(m_addr, ea, {tag, ":m_addr"});
        if (ewe) chk(m_wdata, c_wdata, {tag, ":m_wdata"});
        n  = '0;
        va = v_addr + VB;
        if (ec && !c_we) begin
            n.c = 1'b1;
            n.d = exp_word(c_addr[11:2]);
        end else if (ev) begin
            n.v = 1'b1;
            n.d = exp_word(va[11:2]);
        end
        q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h0; c_wdata = 32'h0;
        v_req = 1'b1; v_addr = 32'h0;

        // Reset: grants and RAM strobes forced low even with both requests up
        #3;
        chk(32'(c_gnt), 32'd0, "rst:c_gnt");
        chk(32'(v_gnt), 32'd0, "rst:v_gnt");
        chk(32'(m_en), 32'd0, "rst:m_en");
        chk(32'(m_we), 32'd0, "rst:m_we");
        chk(32'(c_rvalid), 32'd0, "rst:c_rvalid");
        chk(32'(v_rvalid), 32'd0, "rst:v_rvalid");
        chk(c_rdata, 32'd0, "rst:c_rdata");
        chk(v_rdata, 32'd0, "rst:v_rdata");
        @(posedge clk); #1;
        c_req = 1'b0; v_req = 1'b0;
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        step(0, 0, 0, 32'h0, "idle0");

        // CPU-only read
        c_req = 1'b1; c_addr = 32'h10;
        step(1, 0, 0, 32'h10, "cpu_rd");
        c_req = 1'b0;
        step(0, 0, 0, 32'h0, "cpu_rd_ret");

        // Video-only read with base offset
        v_req = 1'b1; v_addr = 32'h7;
        step(0, 1, 0, 32'h204, "vid_rd");
        v_req = 1'b0;
        step(0, 0, 0, 32'h0, "vid_rd_ret");

        // Back-to-back CPU reads, second one unaligned
        c_req = 1'b1; c_addr = 32'h20;
        step(1, 0, 0, 32'h20, "b2b0");
        c_addr = 32'h27;
        step(1, 0, 0, 32'h24, "b2b1");
        c_req = 1'b0;
        step(0, 0, 0, 32'h0, "b2b_ret");

        // CPU write, then read it back
        c_req = 1'b1; c_we = 1'b1; c_addr = 32'h40; c_wdata = 32'hDEADBEEF;
        step(1, 0, 1, 32'h40, "cpu_wr");
        c_req = 1'b0; c_we = 1'b0;
        step(0, 0, 0, 32'h0, "cpu_wr_norv");
        c_req = 1'b1;
        step(1, 0, 0, 32'h40, "cpu_rdback");
        c_req = 1'b0;
        step(0, 0, 0, 32'h0, "cpu_rdback_ret");
        chk(c_rdata, 32'hDEADBEEF, "rdback_data");

        // Video address wrap
        v_req = 1'b1; v_addr = 32'hFFFFFF00;
        step(0, 1, 0, 32'h100, "wrap");
        v_req = 1'b0;
        step(0, 0, 0, 32'h0, "wrap_ret");

        // Contention: V,V,V,V,C repeating
        c_req = 1'b1; c_addr = 32'h80; v_req = 1'b1; v_addr = 32'h0;
        for (int i = 0; i < 10; i++) begin
            step((i % 5) == 4, (i % 5) != 4, 0,
                 ((i % 5) == 4) ? 32'h80 : 32'h200, "contend");
        end

        // Four more video wins puts the CPU next in line; reset must undo that and drop the pending return
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 32'h200, "pre_rst");
        end
        reset_n = 1'b0;
        #1;
        chk(32'(c_gnt), 32'd0, "mid_rst:c_gnt");
        chk(32'(v_gnt), 32'd0, "mid_rst:v_gnt");
        chk(32'(m_en), 32'd0, "mid_rst:m_en");
        chk(32'(v_rvalid), 32'd0, "mid_rst:v_rvalid");
        chk(32'(c_rvalid), 32'd0, "mid_rst:c_rvalid");
        #1 reset_n = 1'b1;
        q.delete();
        chk(v_rdata, 32'd0, "post_rst:v_rdata");
        chk(c_rdata, 32'd0, "post_rst:c_rdata");

        // After reset video is favoured again; a CPU drop mid-streak restarts the count
        step(0, 1, 0, 32'h200, "post_rst_v0");
        step(0, 1, 0, 32'h200, "post_rst_v1");
        c_req = 1'b0;
        step(0, 1, 0, 32'h200, "clr_v");
        c_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 32'h200, "restreak");
        end
        step(1, 0, 0, 32'h80, "restreak_c");
        c_req = 1'b0; v_req = 1'b0;
        step(0, 0, 0, 32'h0, "final_ret");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
